// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by an oversampled baud tick: synchronises rx,
// validates the start bit, centre-samples data and stop bits, strobes each byte.
module uart_rx #(
   parameter int OVERSAMPLE = 8,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t                state_q, state_d;
   logic                  rx_meta_q, rx_s_q;
   logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
   logic [BW-1:0]         bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0]  shreg_q, shreg_d;
   logic [DATA_BITS-1:0]  data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  frame_err_q, frame_err_d;

   // Two-flop synchroniser, idles high so reset never looks like a start edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tick_cnt_q  <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            // Start edge is watched every clock, not only on ticks
            if (!rx_s_q) begin
               state_d    = START;
               tick_cnt_d = '0;
            end
         end
         START: begin
            if (baud_tick) begin
               if (tick_cnt_q == HALF_M1) begin
                  tick_cnt_d = '0;
                  bit_idx_d  = '0;
                  state_d    = rx_s_q ? IDLE : DATA;
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
         end
         DATA: begin
            if (baud_tick) begin
               if (tick_cnt_q == FULL_M1) begin
                  shreg_d[bit_idx_q] = rx_s_q;
                  tick_cnt_d         = '0;
                  if (bit_idx_q == LAST_BIT) state_d = STOP;
                  else                       bit_idx_d = bit_idx_q + BW'(1);
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
         end
         STOP: begin
            if (baud_tick) begin
               if (tick_cnt_q == FULL_M1) begin
                  tick_cnt_d = '0;
                  if (rx_s_q) begin
                     data_d  = shreg_q;
                     valid_d = 1'b1;
                     state_d = IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = WAIT_IDLE;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
         end
         // A held-low line (break) must rise before another start is accepted
         WAIT_IDLE: begin
            if (rx_s_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: frames are serialised from byte values and the
// expected byte stream / error count is kept as a queue-based reference model.
module tb_uart_rx;

   localparam int OS  = 8;
   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       baud_tick;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] exp_data = 8'h00;
   int valid_cnt = 0, ferr_cnt = 0;
   int exp_valid = 0, exp_ferr = 0;
   logic valid_prev = 1'b0, ferr_prev = 1'b0, busy_prev = 1'b0;

   uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx),
      .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   initial begin
      baud_tick = 1'b0;
      forever begin
         repeat (DIV - 1) @(posedge clk);
         #1 baud_tick = 1'b1;
         @(posedge clk);
         #1 baud_tick = 1'b0;
      end
   end

   // Output monitor: every pulse is matched against the reference model
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid || frame_err) check("valid_ferr_excl", {31'd0, valid && frame_err}, 0);
         if (valid) begin
            valid_cnt++;
            check("valid_width", {31'd0, valid_prev}, 0);
            check("busy_fall", {30'd0, busy_prev, busy}, 32'h2);
            check("valid_expected", {31'd0, exp_q.size() > 0}, 1);
            if (exp_q.size() > 0) begin
               exp_data = exp_q.pop_front();
               check("rx_byte", {24'd0, data}, {24'd0, exp_data});
            end
         end
         if (frame_err) begin
            ferr_cnt++;
            check("ferr_width", {31'd0, ferr_prev}, 0);
            check("ferr_data_hold", {24'd0, data}, {24'd0, exp_data});
         end
      end
      valid_prev = valid;
      ferr_prev  = frame_err;
      busy_prev  = busy;
   end

   task automatic wait_tick();
      do @(posedge clk); while (baud_tick !== 1'b1);
      #2;
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) wait_tick();
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      wait_ticks(OS);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      wait_tick();
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   task automatic send_good(input logic [7:0] d);
      exp_q.push_back(d);
      exp_valid++;
      send_frame(d, 1'b1);
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_valid_cnt"}, valid_cnt, exp_valid);
      check({tag, "_ferr_cnt"}, ferr_cnt, exp_ferr);
   endtask

   task automatic do_reset(input logic rx_level);
      rx    = rx_level;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      exp_q.delete();
      exp_data = 8'h00;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      logic [7:0] c3;
      rst_n = 1'b1;
      rx    = 1'b1;
      #3;
      do_reset(1'b1);
      check("rst_data", {24'd0, data}, 0);
      check("rst_valid", {31'd0, valid}, 0);
      check("rst_ferr", {31'd0, frame_err}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      rst_n = 1'b1;
      wait_ticks(100);
      check("idle_busy", {31'd0, busy}, 0);
      check_counts("idle");

      send_good(8'hA5);
      check_counts("single");
      check("single_data", {24'd0, data}, 32'hA5);
      check("single_busy", {31'd0, busy}, 0);

      send_good(8'h00);
      send_good(8'hFF);
      send_good(8'h3C);
      check_counts("b2b");
      check("b2b_data", {24'd0, data}, 32'h3C);

      // Glitch shorter than half a bit
      wait_tick();
      rx = 1'b0;
      wait_ticks(2);
      rx = 1'b1;
      wait_ticks(OS);
      check("glitch_busy", {31'd0, busy}, 0);
      check_counts("glitch");
      send_good(8'h5A);
      check_counts("after_glitch");
      check("after_glitch_data", {24'd0, data}, 32'h5A);

      // Framing error followed by a break of three bit times
      exp_ferr++;
      send_frame(8'h81, 1'b0);
      wait_ticks(3 * OS);
      check_counts("ferr");
      check("ferr_busy_held", {31'd0, busy}, 1);
      check("ferr_data", {24'd0, data}, 32'h5A);
      rx = 1'b1;
      wait_ticks(OS);
      check("ferr_busy_release", {31'd0, busy}, 0);
      send_good(8'h42);
      check_counts("after_ferr");
      check("after_ferr_data", {24'd0, data}, 32'h42);

      // Reset mid-frame after four data bits
      c3 = 8'hC3;
      wait_tick();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(c3[i]);
      do_reset(1'b1);
      rst_n = 1'b1;
      check("midrst_data", {24'd0, data}, 0);
      check("midrst_busy", {31'd0, busy}, 0);
      wait_ticks(2 * OS);
      check_counts("midrst");
      send_good(8'h17);
      check_counts("after_midrst");
      check("after_midrst_data", {24'd0, data}, 32'h17);

      // Line held low out of reset gives exactly one frame error
      do_reset(1'b0);
      rst_n = 1'b1;
      exp_ferr++;
      wait_ticks(12 * OS);
      check_counts("break");
      check("break_busy", {31'd0, busy}, 1);
      check("break_data", {24'd0, data}, 0);
      rx = 1'b1;
      wait_ticks(OS);
      check("break_release_busy", {31'd0, busy}, 0);

      // Randomised traffic with occasional bad stop bits and idle gaps
      for (int n = 0; n < 24; n++) begin
         b = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 5) == 0) begin
            exp_ferr++;
            send_frame(b, 1'b0);
            wait_ticks($urandom_range(0, 16));
            rx = 1'b1;
         end else begin
            send_good(b);
         end
         repeat ($urandom_range(0, 40)) @(posedge clk);
         #2;
      end
      wait_ticks(2 * OS);
      check_counts("random");
      check("random_data", {24'd0, data}, {24'd0, exp_data});
      check("random_queue_empty", exp_q.size(), 0);
      check("random_busy", {31'd0, busy}, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the existing uart_tx.
- Driven by the 8x-oversampled RX baud tick: 651-clock divider at 50 MHz for 9600 baud.
- Synchronises the asynchronous serial line, detects and validates the start bit, centre-samples the data and stop bits, and presents each byte with a one-cycle valid strobe.
- Sits in tt_um_javibajocero_top beside uart_tx; rx comes from a ui_in pin.

Parameters:
OVERSAMPLE, 8, baud_tick pulses per bit period; must be even and >= 4
DATA_BITS, 8, data bits per frame, LSB first

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
baud_tick  input  1  one-clk strobe, OVERSAMPLE per bit period
rx  input  1  asynchronous serial line, idle high
data  output  DATA_BITS  last correctly framed byte; holds until the next good frame
valid  output  1  one-clk pulse; data updated in the same cycle
frame_err  output  1  one-clk pulse; stop bit sampled low
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low (rst_n). On reset:
  - data = 0, valid = 0, frame_err = 0, busy = 0.
  - Both synchroniser flops = 1.
  - State = IDLE; tick_cnt = 0; bit_idx = 0; shift register = 0.
  - rst_n low mid-frame aborts the frame with no valid/frame_err pulse.
- Synchroniser: two flops on rx give rx_s. All decisions use rx_s, so line latency is 2 clk.
- Counters:
  - tick_cnt is $clog2(OVERSAMPLE) bits.
  - It advances only on cycles with baud_tick = 1.
  - Outside baud_tick cycles, all state, counters and shift register hold.
- IDLE:
  - rx_s == 0 (checked every clk, not only on ticks) -> START, tick_cnt = 0.
- START:
  - On each baud_tick, tick_cnt increments.
  - On the tick where tick_cnt == OVERSAMPLE/2-1 (the 4th tick, mid start bit), sample rx_s:
    - rx_s == 0 -> DATA, tick_cnt = 0, bit_idx = 0.
    - rx_s == 1 -> glitch/false start -> IDLE, no output pulse.
- DATA:
  - On the tick where tick_cnt == OVERSAMPLE-1, shift rx_s in at bit position bit_idx (LSB first) and set tick_cnt = 0.
  - If bit_idx == DATA_BITS-1 -> STOP; otherwise bit_idx++.
  - On all other ticks, tick_cnt++.
- STOP: sample on the OVERSAMPLE-th tick.
  - rx_s == 1: data <= shift register, valid = 1 for exactly the next clk, -> IDLE.
  - rx_s == 0: frame_err = 1 for one clk, data unchanged, -> WAIT_IDLE.
- WAIT_IDLE:
  - busy stays high; -> IDLE on the first clk with rx_s == 1. This prevents a break condition from retriggering START.
- Timing:
  - valid and frame_err are registered: high in the clk after the sampling tick, low the clk after that.
  - Never both high in the same cycle.
- Back-to-back frames: a start edge arriving in the clk after IDLE is re-entered is accepted, so there is no dead time beyond the stop-bit centre.
- No flow control: valid is not held. A consumer that misses the pulse loses only the strobe; data still holds the byte.
- Line held low from reset: START -> DATA -> STOP gives frame_err, then WAIT_IDLE until the line rises. This produces exactly one frame_err per low period.

Test Plan:
- Reset check: assert rst_n = 0 with rx = 1 -> data = 0x00, valid = 0, frame_err = 0, busy = 0; stays idle for 100 ticks.
- Single byte: send 0xA5 as 8N1 at an 8-tick bit period -> one valid pulse exactly 1 clk wide, data = 0xA5, busy falls with valid, frame_err never high.
- Back-to-back bytes: send 0x00, 0xFF, 0x3C with no idle gap -> three valid pulses, data sequence 0x00, 0xFF, 0x3C, no frame_err.
- Glitch rejection: pulse rx low for 2 ticks (< OVERSAMPLE/2), then send 0x5A -> glitch returns to IDLE silently; 0x5A received correctly.
- Framing error: send 0x81 with the stop bit forced to 0, hold low 3 more bit times, then release and send 0x42 -> one frame_err pulse, data stays at its prior value, busy high until rx returns high, then valid with data = 0x42.
- Mid-frame reset: assert rst_n after 4 data bits of 0xC3, release, then send 0x17 -> no pulse for the aborted frame; data = 0x17 with a single valid.
